// File: rtl/major_state_pkg.sv
// major_state_pkg: shared types and constants for the major state sequencer.
// Sequencer state enum, major-state encodings, opcode values and the bit
// positions inside the one-hot adder select buses.
package major_state_pkg;

  // Sequencer states: each time state is a setup half (SU) then a strobe
  // half (SB); TS2 also has a wait state for the memory handshake.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TS1_SU,
    ST_TS1_SB,
    ST_TS2_WT,
    ST_TS2_SU,
    ST_TS2_SB,
    ST_TS3_SU,
    ST_TS3_SB,
    ST_TS4_SU,
    ST_TS4_SB
  } seq_state_e;

  typedef enum logic [1:0] {
    MAJ_FETCH = 2'b00,
    MAJ_DEFER = 2'b01,
    MAJ_EXEC  = 2'b10
  } major_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;

  // a1_sel bit positions (one-hot, bit 0 = first listed source)
  localparam int A1_AC     = 0;
  localparam int A1_MQ     = 1;
  localparam int A1_CONST0 = 2;
  localparam int A1_NONE   = 3;

  // a2_sel bit positions
  localparam int A2_PC   = 0;
  localparam int A2_MEM  = 1;
  localparam int A2_DATA = 2;

  localparam logic [1:0] SH_NOSH = 2'b00;
  localparam logic [1:0] SH_AND  = 2'b01;

  // Major state that follows the current one at the end of TS4.
  // Opcodes 6/7 are operate-class no-ops here and never leave FETCH.
  function automatic major_e next_major(input major_e cur,
                                        input logic [2:0] op,
                                        input logic ind);
    major_e nxt;
    nxt = MAJ_FETCH;
    case (cur)
      MAJ_FETCH: begin
        if (op <= OP_JMP) nxt = ind ? MAJ_DEFER : MAJ_EXEC;
      end
      MAJ_DEFER: nxt = MAJ_EXEC;
      default:   nxt = MAJ_FETCH;
    endcase
    return nxt;
  endfunction

  // True in the strobe half of any time state.
  function automatic logic is_strobe(input seq_state_e st);
    return st inside {ST_TS1_SB, ST_TS2_SB, ST_TS3_SB, ST_TS4_SB};
  endfunction

endpackage

// File: rtl/major_state_seq_if.sv
// major_state_seq_if: control/handshake bundle between the major state
// sequencer (master) and the register-slice datapath / memory (slave).
interface major_state_seq_if;
  logic       start;
  logic       stop;
  logic [2:0] mb_op;
  logic       mb_ind;
  logic       mem_start;
  logic       mem_done;
  logic       carry_out;
  logic [3:0] a1_sel;
  logic [2:0] a2_sel;
  logic       cin;
  logic [1:0] sh_sel;
  logic       ma_ld;
  logic       pc_ld;
  logic       mb_ld;
  logic       ac_ld;
  logic       run;
  logic [1:0] major;
  logic [2:0] ir;

  modport master (
    input  start, stop, mb_op, mb_ind, mem_done, carry_out,
    output mem_start, a1_sel, a2_sel, cin, sh_sel,
           ma_ld, pc_ld, mb_ld, ac_ld, run, major, ir
  );

  modport slave (
    output start, stop, mb_op, mb_ind, mem_done, carry_out,
    input  mem_start, a1_sel, a2_sel, cin, sh_sel,
           ma_ld, pc_ld, mb_ld, ac_ld, run, major, ir
  );
endinterface

// File: rtl/major_ts_gen.sv
// major_ts_gen: time-state generator. Walks TS1..TS4 as setup/strobe pairs,
// holds in the TS2 wait state until memory completes, and returns to IDLE
// at an instruction boundary when the top requests a halt.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | not running; leaves on go
// ST_TS1_SU | TS1 setup: memory address selects driven
// ST_TS1_SB | TS1 strobe: ma_ld + mem_start
// ST_TS2_WT | waiting for mem_done (only state that samples it)
// ST_TS2_SU | TS2 setup: memory data selected
// ST_TS2_SB | TS2 strobe: mb_ld
// ST_TS3_SU | TS3 setup: major/opcode dependent selects
// ST_TS3_SB | TS3 strobe
// ST_TS4_SU | TS4 setup
// ST_TS4_SB | TS4 strobe; instruction boundary (halt -> IDLE)
module major_ts_gen
  import major_state_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       go,
  input  logic       mem_done,
  input  logic       halt,
  output seq_state_e state
);

  seq_state_e state_q;
  seq_state_e state_d;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state: fixed setup/strobe cadence, TS2 wait, halt at boundary
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (go) state_d = ST_TS1_SU;
      ST_TS1_SU: state_d = ST_TS1_SB;
      ST_TS1_SB: state_d = ST_TS2_WT;
      ST_TS2_WT: if (mem_done) state_d = ST_TS2_SU;
      ST_TS2_SU: state_d = ST_TS2_SB;
      ST_TS2_SB: state_d = ST_TS3_SU;
      ST_TS3_SU: state_d = ST_TS3_SB;
      ST_TS3_SB: state_d = ST_TS4_SU;
      ST_TS4_SU: state_d = ST_TS4_SB;
      ST_TS4_SB: state_d = halt ? ST_IDLE : ST_TS1_SU;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: rtl/major_state_seq.sv
// major_state_seq: major state sequencer for the register-slice datapath.
// Runs FETCH / DEFER / EXEC major cycles, each made of four time states,
// and drives the adder/shifter selects and register load strobes.
// Optional build macro SINGLE_INST_EN adds the sing_inst input, which stops
// the machine at every instruction boundary as if stop were held high.
module major_state_seq
  import major_state_pkg::*;
(
  input  logic clk,
  input  logic rst,
`ifdef SINGLE_INST_EN
  input  logic sing_inst,
`endif
  major_state_seq_if.master bus
);

  seq_state_e st;
  major_e     major_q;
  major_e     nxt_major;
  logic [2:0] ir_q;
  logic       ind_q;
  logic       skip_q;
  logic       halt_req;
  logic       halt;
  logic       go;
  logic       sb;

  logic [3:0] a1;
  logic [2:0] a2;
  logic       cin_c;
  logic [1:0] sh;
  logic       ld_ma;
  logic       ld_pc;
  logic       ld_mb;
  logic       ld_ac;

`ifdef SINGLE_INST_EN
  assign halt_req = bus.stop | sing_inst;
`else
  assign halt_req = bus.stop;
`endif

  // start with stop also high must not leave IDLE
  assign go        = bus.start & ~bus.stop;
  assign nxt_major = next_major(major_q, ir_q, ind_q);
  // stop only takes effect when the next major cycle would be a fetch,
  // so a multi-cycle instruction always completes
  assign halt      = halt_req & (nxt_major == MAJ_FETCH);
  assign sb        = is_strobe(st);

  major_ts_gen u_ts_gen (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .mem_done (bus.mem_done),
    .halt     (halt),
    .state    (st)
  );

  // Major state, instruction register, indirect and skip flags
  always_ff @(posedge clk) begin
    if (rst) begin
      major_q <= MAJ_FETCH;
      ir_q    <= '0;
      ind_q   <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      if (st == ST_TS2_SB && major_q == MAJ_FETCH) begin
        ir_q  <= bus.mb_op;
        ind_q <= bus.mb_ind;
      end
      if (st == ST_TS3_SB && major_q == MAJ_EXEC && ir_q == OP_ISZ)
        skip_q <= bus.carry_out;
      if (st == ST_TS4_SB)
        major_q <= nxt_major;
    end
  end

  // Selects for the current time state (held across setup and strobe)
  // plus which register the strobe half would load
  always_comb begin
    a1    = '0;
    a2    = '0;
    cin_c = 1'b0;
    sh    = SH_NOSH;
    ld_ma = 1'b0;
    ld_pc = 1'b0;
    ld_mb = 1'b0;
    ld_ac = 1'b0;
    case (st)
      ST_TS1_SU, ST_TS1_SB: begin
        if (major_q == MAJ_FETCH) a2[A2_PC]   = 1'b1;
        else                      a2[A2_DATA] = 1'b1;
        ld_ma = 1'b1;
      end
      ST_TS2_SU, ST_TS2_SB: begin
        a2[A2_MEM] = 1'b1;
        ld_mb      = 1'b1;
      end
      ST_TS3_SU, ST_TS3_SB: begin
        case (major_q)
          MAJ_FETCH: begin
            a2[A2_PC] = 1'b1;
            cin_c     = 1'b1;
            ld_pc     = 1'b1;
          end
          MAJ_DEFER: begin
            a2[A2_MEM] = 1'b1;
            ld_mb      = 1'b1;
          end
          MAJ_EXEC: begin
            case (ir_q)
              OP_AND: begin
                a1[A1_AC]  = 1'b1;
                a2[A2_MEM] = 1'b1;
                sh         = SH_AND;
                ld_ac      = 1'b1;
              end
              OP_TAD: begin
                a1[A1_AC]  = 1'b1;
                a2[A2_MEM] = 1'b1;
                ld_ac      = 1'b1;
              end
              OP_ISZ: begin
                a2[A2_MEM] = 1'b1;
                cin_c      = 1'b1;
                ld_mb      = 1'b1;
              end
              OP_DCA: begin
                a1[A1_AC] = 1'b1;
                ld_mb     = 1'b1;
              end
              OP_JMS: begin
                a2[A2_PC] = 1'b1;
                ld_mb     = 1'b1;
              end
              OP_JMP: begin
                a2[A2_DATA] = 1'b1;
                ld_pc       = 1'b1;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
      ST_TS4_SU, ST_TS4_SB: begin
        if (major_q == MAJ_EXEC) begin
          case (ir_q)
            OP_ISZ: begin
              if (skip_q) begin
                a2[A2_PC] = 1'b1;
                cin_c     = 1'b1;
                ld_pc     = 1'b1;
              end
            end
            OP_DCA: begin
              a1[A1_CONST0] = 1'b1;
              ld_ac         = 1'b1;
            end
            OP_JMS: begin
              a2[A2_DATA] = 1'b1;
              cin_c       = 1'b1;
              ld_pc       = 1'b1;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign bus.a1_sel    = a1;
  assign bus.a2_sel    = a2;
  assign bus.cin       = cin_c;
  assign bus.sh_sel    = sh;
  assign bus.ma_ld     = ld_ma & sb;
  assign bus.pc_ld     = ld_pc & sb;
  assign bus.mb_ld     = ld_mb & sb;
  assign bus.ac_ld     = ld_ac & sb;
  assign bus.mem_start = (st == ST_TS1_SB);
  assign bus.run       = (st != ST_IDLE);
  assign bus.major     = major_q;
  assign bus.ir        = ir_q;

endmodule

// File: tb/tb_major_state_seq.sv
// tb_major_state_seq: directed bench for the major state sequencer.
`timescale 1ns/1ps
module tb_major_state_seq;
  import major_state_pkg::*;

  localparam int C_PC    = 0;
  localparam int C_AC    = 1;
  localparam int C_MB    = 2;
  localparam int C_MA    = 3;
  localparam int C_MEM   = 4;
  localparam int C_MULTI = 5;
  localparam int C_DEFER = 6;
  localparam int C_EXEC  = 7;
  localparam int C_CINPC = 8;

  typedef struct {
    logic [2:0] op;
    logic       ind;
    logic       cy;
    int         pc;
    int         ac;
    int         mb;
    int         mem;
    int         cinpc;
    logic       defer;
    logic       exec;
    logic [3:0] a1;
    logic [2:0] a2;
    logic [1:0] sh;
  } vec_t;

  // op ind cy | pc_ld ac_ld mb_ld mem_start pc_ld-with-cin | defer exec | ac_ld selects
  vec_t vecs [10] = '{
    '{3'd7, 1'b1, 1'b0, 1, 0, 1, 1, 1, 1'b0, 1'b0, 4'b0000, 3'b000, 2'b00},
    '{3'd6, 1'b0, 1'b0, 1, 0, 1, 1, 1, 1'b0, 1'b0, 4'b0000, 3'b000, 2'b00},
    '{3'd1, 1'b0, 1'b0, 1, 1, 2, 2, 1, 1'b0, 1'b1, 4'b0001, 3'b010, 2'b00},
    '{3'd0, 1'b0, 1'b0, 1, 1, 2, 2, 1, 1'b0, 1'b1, 4'b0001, 3'b010, 2'b01},
    '{3'd2, 1'b1, 1'b1, 2, 0, 5, 3, 2, 1'b1, 1'b1, 4'b0000, 3'b000, 2'b00},
    '{3'd2, 1'b0, 1'b0, 1, 0, 3, 2, 1, 1'b0, 1'b1, 4'b0000, 3'b000, 2'b00},
    '{3'd3, 1'b0, 1'b0, 1, 1, 3, 2, 1, 1'b0, 1'b1, 4'b0100, 3'b000, 2'b00},
    '{3'd4, 1'b0, 1'b0, 2, 0, 3, 2, 2, 1'b0, 1'b1, 4'b0000, 3'b000, 2'b00},
    '{3'd5, 1'b0, 1'b0, 2, 0, 2, 2, 1, 1'b0, 1'b1, 4'b0000, 3'b000, 2'b00},
    '{3'd5, 1'b1, 1'b0, 2, 0, 4, 3, 1, 1'b1, 1'b1, 4'b0000, 3'b000, 2'b00}
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  major_state_seq_if bus ();

  logic mem_resp = 1'b0;
  logic mem_kick = 1'b0;
  logic mem_auto = 1'b1;
  int   mem_cnt  = 0;
  assign bus.mem_done = mem_resp | mem_kick;

`ifdef SINGLE_INST_EN
  logic sing_inst = 1'b0;
`endif

  major_state_seq dut (
    .clk       (clk),
    .rst       (rst),
`ifdef SINGLE_INST_EN
    .sing_inst (sing_inst),
`endif
    .bus       (bus)
  );

  int unsigned cnt  [9] = '{default: 0};
  int unsigned base [9] = '{default: 0};
  logic [3:0]  cap_a1 = '0;
  logic [2:0]  cap_a2 = '0;
  logic [1:0]  cap_sh = '0;
  int          errors = 0;
  int          checks = 0;

  // Mid-cycle monitor and memory responder (mem_done 3 cycles after mem_start)
  always @(negedge clk) begin
    if (bus.pc_ld) cnt[C_PC]++;
    if (bus.pc_ld && bus.cin) cnt[C_CINPC]++;
    if (bus.ac_ld) begin
      cnt[C_AC]++;
      cap_a1 = bus.a1_sel;
      cap_a2 = bus.a2_sel;
      cap_sh = bus.sh_sel;
    end
    if (bus.mb_ld) cnt[C_MB]++;
    if (bus.ma_ld) cnt[C_MA]++;
    if (bus.mem_start) cnt[C_MEM]++;
    if (int'(bus.pc_ld) + int'(bus.ac_ld) + int'(bus.mb_ld) + int'(bus.ma_ld) > 1)
      cnt[C_MULTI]++;
    if (bus.run && bus.major == MAJ_DEFER) cnt[C_DEFER]++;
    if (bus.run && bus.major == MAJ_EXEC)  cnt[C_EXEC]++;
    mem_resp = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) mem_resp = mem_auto;
    end
    if (bus.mem_start) mem_cnt = 3;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag, input int lim);
    int n;
    n = 0;
    while (bus.run && n < lim) begin
      tick();
      n++;
    end
    chk(tag, 32'(bus.run), 32'd0);
  endtask

  task automatic wait_mem_start(input logic [1:0] maj, input int lim, output logic found);
    int n;
    n = 0;
    found = 1'b0;
    while (!found && n < lim) begin
      if (bus.mem_start && bus.major == maj) found = 1'b1;
      else begin
        tick();
        n++;
      end
    end
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    bus.mb_op     = v.op;
    bus.mb_ind    = v.ind;
    bus.carry_out = v.cy;
    bus.stop      = 1'b0;
    base = cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b1;
    chk($sformatf("v%0d_run_up", i), 32'(bus.run), 32'd1);
    wait_idle($sformatf("v%0d_run_done", i), 200);
    chk($sformatf("v%0d_pc_ld", i), cnt[C_PC] - base[C_PC], v.pc);
    chk($sformatf("v%0d_ac_ld", i), cnt[C_AC] - base[C_AC], v.ac);
    chk($sformatf("v%0d_mb_ld", i), cnt[C_MB] - base[C_MB], v.mb);
    chk($sformatf("v%0d_mem_start", i), cnt[C_MEM] - base[C_MEM], v.mem);
    chk($sformatf("v%0d_ma_ld", i), cnt[C_MA] - base[C_MA], v.mem);
    chk($sformatf("v%0d_pc_cin", i), cnt[C_CINPC] - base[C_CINPC], v.cinpc);
    chk($sformatf("v%0d_multi", i), cnt[C_MULTI] - base[C_MULTI], 32'd0);
    chk($sformatf("v%0d_defer", i), 32'(cnt[C_DEFER] != base[C_DEFER]), 32'(v.defer));
    chk($sformatf("v%0d_exec", i), 32'(cnt[C_EXEC] != base[C_EXEC]), 32'(v.exec));
    chk($sformatf("v%0d_ir", i), 32'(bus.ir), 32'(v.op));
    chk($sformatf("v%0d_major", i), 32'(bus.major), 32'(MAJ_FETCH));
    if (v.ac != 0) begin
      chk($sformatf("v%0d_ac_a1", i), 32'(cap_a1), 32'(v.a1));
      chk($sformatf("v%0d_ac_a2", i), 32'(cap_a2), 32'(v.a2));
      chk($sformatf("v%0d_ac_sh", i), 32'(cap_sh), 32'(v.sh));
    end
  endtask

  initial begin
    logic found;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.mb_op     = 3'd0;
    bus.mb_ind    = 1'b0;
    bus.carry_out = 1'b0;

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_run", 32'(bus.run), 32'd0);
    chk("rst_major", 32'(bus.major), 32'(MAJ_FETCH));
    chk("rst_ir", 32'(bus.ir), 32'd0);
    chk("rst_outs", 32'({bus.a1_sel, bus.a2_sel, bus.cin, bus.sh_sel, bus.ma_ld,
                         bus.pc_ld, bus.mb_ld, bus.ac_ld, bus.mem_start}), 32'd0);

    // start and stop together must not leave IDLE
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    repeat (3) tick();
    chk("start_stop_idle", 32'(bus.run), 32'd0);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    tick();

    for (int i = 0; i < 10; i++) run_vec(i);

    // stop raised during EXEC TS2: instruction completes, then nothing more
    bus.mb_op     = 3'd1;
    bus.mb_ind    = 1'b0;
    bus.carry_out = 1'b0;
    bus.stop      = 1'b0;
    base = cnt;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_mem_start(MAJ_EXEC, 100, found);
    chk("stop_exec_ts1_seen", 32'(found), 32'd1);
    tick();
    bus.stop = 1'b1;
    wait_idle("stop_run_done", 100);
    chk("stop_mem_start", cnt[C_MEM] - base[C_MEM], 32'd2);
    chk("stop_ac_ld", cnt[C_AC] - base[C_AC], 32'd1);
    base = cnt;
    repeat (30) tick();
    chk("stop_no_more_mem", cnt[C_MEM] - base[C_MEM], 32'd0);
    chk("stop_still_idle", 32'(bus.run), 32'd0);

    // reset in the TS2 wait, then a late mem_done must be ignored
    mem_auto  = 1'b0;
    bus.stop  = 1'b0;
    bus.mb_op = 3'd4;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_mem_start(MAJ_FETCH, 50, found);
    chk("rstw_ts1_seen", 32'(found), 32'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    base = cnt;
    mem_kick = 1'b1;
    tick();
    mem_kick = 1'b0;
    repeat (8) tick();
    chk("rstw_run", 32'(bus.run), 32'd0);
    chk("rstw_mb_ld", cnt[C_MB] - base[C_MB], 32'd0);
    chk("rstw_strobes", (cnt[C_PC] - base[C_PC]) + (cnt[C_AC] - base[C_AC]) +
                        (cnt[C_MA] - base[C_MA]) + (cnt[C_MEM] - base[C_MEM]), 32'd0);
    chk("rstw_major", 32'(bus.major), 32'(MAJ_FETCH));
    chk("rstw_ir", 32'(bus.ir), 32'd0);
    mem_auto = 1'b1;

    // recovery after reset
    run_vec(2);

`ifdef SINGLE_INST_EN
    bus.stop  = 1'b0;
    sing_inst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus.mb_op  = (k == 0) ? 3'd1 : 3'd7;
      bus.mb_ind = 1'b0;
      base = cnt;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      chk($sformatf("si%0d_run_up", k), 32'(bus.run), 32'd1);
      wait_idle($sformatf("si%0d_run_done", k), 100);
      chk($sformatf("si%0d_mem_start", k), cnt[C_MEM] - base[C_MEM], (k == 0) ? 32'd2 : 32'd1);
      repeat (10) tick();
      chk($sformatf("si%0d_stays_idle", k), 32'(bus.run), 32'd0);
    end
    sing_inst = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/major_state_seq.md
MAJOR_STATE_SEQ -- requirements
Module: major_state_seq

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL have: start  in  1  level; begin running from IDLE.
REQ-004 SHALL have: stop  in  1  level; halt at next instruction boundary.
REQ-005 SHALL have: mb_op  in  3  opcode bits MB[0:2] from the register slices; mb_ind  in  1  indirect bit MB[3].
REQ-006 SHALL have: mem_start  out  1  one-cycle memory request; mem_done  in  1  memory cycle complete.
REQ-007 SHALL have: carry_out  in  1  adder carry from the slice chain.
REQ-008 SHALL have: a1_sel  out  4  one-hot adder arg1 source {ac, mq, const0, none}; a2_sel  out  3  one-hot arg2 source {pc, mem, data_addr}; cin  out  1  adder carry-in.
REQ-009 SHALL have: sh_sel  out  2  shifter op {00 nosh, 01 and, others reserved}.
REQ-010 SHALL have: ma_ld, pc_ld, mb_ld, ac_ld  out  1 each  register load strobes.
REQ-011 SHALL have: run  out  1; major  out  2  {00 FETCH, 01 DEFER, 10 EXEC}; ir  out  3  latched opcode.

Function
REQ-012 SHALL sequence states IDLE, TS1, TS2, TS3, TS4; each TS is a setup cycle (selects driven, strobes 0) then a strobe cycle (selects held, one strobe high), because slices load on strobe rising edge from the previous cycle's shifter value.
REQ-013 IDLE: run=0, all selects/strobes 0; start=1 -> TS1 setup, major=FETCH, run=1 next cycle.
REQ-014 TS1: mem_start=1 in strobe cycle; FETCH: a2=pc, nosh, ma_ld; DEFER/EXEC: a2=data_addr, nosh, ma_ld.
REQ-015 TS2: wait, selects 0, until mem_done=1 (sampled only in TS2; mem_done in any other state ignored); then one setup+strobe with a2=mem, mb_ld; FETCH latches ir<=mb_op, ind<=mb_ind in the strobe cycle.
REQ-016 TS3 FETCH: a2=pc, cin=1, pc_ld (PC+1). DEFER: a2=mem, mb_ld. EXEC per ir: 0 AND a1=ac, a2=mem, sh=and, ac_ld; 1 TAD a1=ac, a2=mem, ac_ld; 2 ISZ a2=mem, cin=1, mb_ld, skip flag<=carry_out at strobe; 3 DCA a1=ac, mb_ld; 4 JMS a2=pc, mb_ld; 5 JMP a2=data_addr, pc_ld.
REQ-017 TS4 EXEC: ISZ with skip=1 -> a2=pc, cin=1, pc_ld; DCA -> a1=const0, ac_ld; JMS -> a2=data_addr, cin=1, pc_ld; else no strobe.
REQ-018 Next major at end of TS4: FETCH with ir<=5 and ind=1 -> DEFER; FETCH with ir<=5 and ind=0 -> EXEC, except ir=5 ind=0 -> EXEC; DEFER -> EXEC; EXEC -> FETCH; FETCH with ir 6/7 -> FETCH (no-op).
REQ-019 stop sampled at end of TS4 only when next major=FETCH; stop=1 -> IDLE, run=0; stop mid-cycle SHALL complete the instruction.
REQ-020 start while run=1 SHALL be ignored; start and stop both high in IDLE -> remain IDLE.
REQ-021 At most one load strobe high in any cycle; mem_start high exactly once per TS1.

Reset
REQ-022 rst=1 in any state, including TS2 wait -> IDLE, major=FETCH, ir=0, ind=0, skip=0, all outputs 0 next cycle; an outstanding mem_done after reset SHALL be ignored.

Configuration
REQ-023 Macro SINGLE_INST_EN: when defined, input sing_inst (1 bit) added; sing_inst=1 forces IDLE at every instruction boundary as if stop=1. When undefined, port absent and behaviour per REQ-019.

Structure
REQ-024 Package major_state_pkg SHALL hold state enum, major encodings, opcode constants, select bit indices.
REQ-025 Sub-module major_ts_gen SHALL implement the TS setup/strobe counter and TS2 wait; opcode decode stays in the top.

Verification
REQ-026 Reset then start=1, mem_done 3 cycles after mem_start, mb_op=7: FETCH only; pc_ld once, ir=7, major stays FETCH.
REQ-027 mb_op=1, mb_ind=0: FETCH then EXEC; ac_ld once in EXEC TS3 with a1=ac, a2=mem.
REQ-028 mb_op=2, mb_ind=1, carry_out=1 at EXEC TS3: DEFER visited, then two pc_ld total in EXEC-to-end (skip).
REQ-029 stop=1 asserted during EXEC TS2: instruction completes, run=0 after TS4, no further mem_start.
REQ-030 rst=1 during TS2 wait then mem_done=1: all strobes 0, state IDLE, no mb_ld.
REQ-031 SINGLE_INST_EN, sing_inst=1: each start executes exactly one instruction then IDLE.
